// File: rtl/fifo_wr_arbiter.sv
// Round-robin scheduler for the async FIFO write port; owns binary and Gray write pointers.
// Latency: Req sampled at edge k -> Ack/Wr_en high during cycle k+1; one word per cycle.
// Backpressure: Full_sig blocks all grants (FSM in STALL); optional WR_ARB_STALL_CNT_EN adds Stall_cnt.
module fifo_wr_arbiter #(
    parameter int Addr_width = 5,
    parameter int Data_width = 8,
    parameter int N_REQ      = 4
) (
    input  logic                          Wr_clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              Req,
    input  logic [N_REQ*Data_width-1:0]   Req_data,
    input  logic                          Full_sig,
    output logic [N_REQ-1:0]              Ack,
    output logic                          Wr_en,
    output logic [Addr_width-1:0]         Wr_addr,
    output logic [Data_width-1:0]         Wr_data,
    output logic [Addr_width:0]           Wr_point,
    output logic [Addr_width:0]           Wr_point_gray,
    output logic                          Stall
`ifdef WR_ARB_STALL_CNT_EN
    ,
    output logic [15:0]                   Stall_cnt
`endif
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           last_q, last_d;
    logic [N_REQ-1:0]        ack_q, ack_d;
    logic                    wr_en_q, wr_en_d;
    logic [Addr_width-1:0]   wr_addr_q, wr_addr_d;
    logic [Data_width-1:0]   wr_data_q, wr_data_d;
    logic [Addr_width:0]     wr_point_q, wr_point_d;
    logic [Addr_width:0]     wr_point_gray_q, wr_point_gray_d;
    logic                    stall_q, stall_d;
    logic                    any_req;
    logic                    grant;
    logic                    found;
    logic [LW-1:0]           win;
`ifdef WR_ARB_STALL_CNT_EN
    logic [15:0]             stall_cnt_q, stall_cnt_d;
`endif

    always_comb begin
        any_req = |Req;
        grant   = any_req && !Full_sig;

        // Search starts just past the last winner so every requester gets a turn.
        found = 1'b0;
        win   = last_q;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && Req[(int'(last_q) + k) % N_REQ]) begin
                found = 1'b1;
                win   = LW'((int'(last_q) + k) % N_REQ);
            end
        end

        ack_d      = '0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_point_d = wr_point_q;
        last_d     = last_q;
        if (grant) begin
            ack_d[win] = 1'b1;
            wr_en_d    = 1'b1;
            wr_addr_d  = wr_point_q[Addr_width-1:0];
            wr_data_d  = Req_data[int'(win)*Data_width +: Data_width];
            wr_point_d = wr_point_q + {{Addr_width{1'b0}}, 1'b1};
            last_d     = win;
        end
        wr_point_gray_d = wr_point_d ^ (wr_point_d >> 1);

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req && !Full_sig)     state_d = RUN;
                else if (any_req && Full_sig) state_d = STALL;
            end
            RUN: begin
                if (!any_req)      state_d = IDLE;
                else if (Full_sig) state_d = STALL;
            end
            STALL: begin
                if (!any_req)       state_d = IDLE;
                else if (!Full_sig) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        stall_d = (state_d == STALL);

`ifdef WR_ARB_STALL_CNT_EN
        stall_cnt_d = stall_cnt_q;
        if (any_req && Full_sig && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
`endif
    end

    always_ff @(posedge Wr_clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            last_q          <= LW'(N_REQ - 1);
            ack_q           <= '0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= '0;
            wr_point_q      <= '0;
            wr_point_gray_q <= '0;
            stall_q         <= 1'b0;
`ifdef WR_ARB_STALL_CNT_EN
            stall_cnt_q     <= '0;
`endif
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            ack_q           <= ack_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            wr_point_q      <= wr_point_d;
            wr_point_gray_q <= wr_point_gray_d;
            stall_q         <= stall_d;
`ifdef WR_ARB_STALL_CNT_EN
            stall_cnt_q     <= stall_cnt_d;
`endif
        end
    end

    assign Ack           = ack_q;
    assign Wr_en         = wr_en_q;
    assign Wr_addr       = wr_addr_q;
    assign Wr_data       = wr_data_q;
    assign Wr_point      = wr_point_q;
    assign Wr_point_gray = wr_point_gray_q;
    assign Stall         = stall_q;
`ifdef WR_ARB_STALL_CNT_EN
    assign Stall_cnt     = stall_cnt_q;
`endif

endmodule
